// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// One operation in flight at a time: IDLE -> WAIT (ALU latency) -> RESP (hold until taken).
module alu_req_arbiter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [DATA_W-1:0] REQ0_OP_A,
  input  logic [DATA_W-1:0] REQ0_OP_B,
  input  logic [DATA_W-1:0] REQ0_OPCODE,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [DATA_W-1:0] REQ1_OP_A,
  input  logic [DATA_W-1:0] REQ1_OP_B,
  input  logic [DATA_W-1:0] REQ1_OPCODE,
  output logic [DATA_W-1:0] ALU_OP_A,
  output logic [DATA_W-1:0] ALU_OP_B,
  output logic [DATA_W-1:0] ALU_OPCODE,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              ALU_CARRY,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_ID,
  output logic [DATA_W-1:0] RSP_RESULT,
  output logic              RSP_CARRY,
  output logic              BUSY,
  output logic [CNT_W-1:0]  CNT0,
  output logic [CNT_W-1:0]  CNT1
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [2:0] LatInit = 3'(ALU_LATENCY);

  logic [1:0]        state_q;
  logic              ptr_q;
  logic              id_q;
  logic [2:0]        wait_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;

  logic both_valid;
  logic any_valid;
  logic gnt_id;
  logic accept;

  // On a tie, grant whoever was not served last.
  always_comb begin
    both_valid = REQ0_VALID & REQ1_VALID;
    any_valid  = REQ0_VALID | REQ1_VALID;
    gnt_id     = both_valid ? ~ptr_q : REQ1_VALID;
    accept     = (state_q == StIdle) & any_valid & ~RESET;
  end

  assign REQ0_READY = accept & ~gnt_id;
  assign REQ1_READY = accept &  gnt_id;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b1;
      id_q     <= 1'b0;
      wait_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_a_q   <= gnt_id ? REQ1_OP_A   : REQ0_OP_A;
            op_b_q   <= gnt_id ? REQ1_OP_B   : REQ0_OP_B;
            opcode_q <= gnt_id ? REQ1_OPCODE : REQ0_OPCODE;
            id_q     <= gnt_id;
            ptr_q    <= gnt_id;
            wait_q   <= LatInit;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (wait_q == 3'd0) begin
            result_q <= ALU_OUT;
            carry_q  <= ALU_CARRY;
            state_q  <= StResp;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        StResp: begin
          if (RSP_READY) begin
            // Counters saturate at all-ones.
            if (id_q) begin
              if (cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
            end else begin
              if (cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ALU_OP_A   = op_a_q;
  assign ALU_OP_B   = op_b_q;
  assign ALU_OPCODE = opcode_q;
  assign RSP_VALID  = (state_q == StResp);
  assign RSP_ID     = id_q;
  assign RSP_RESULT = result_q;
  assign RSP_CARRY  = carry_q;
  assign BUSY       = (state_q != StIdle);
  assign CNT0       = cnt0_q;
  assign CNT1       = cnt1_q;

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the single registered 8-bit ALU (alu_8_bit) between two requesters (REQ0, REQ1).
- Accepts one operation at a time through a valid/ready handshake, using round-robin arbitration.
- Drives the ALU operand and opcode ports, waits the ALU pipeline latency, captures ALU_OUT/CARRY, and returns the tagged result on one response channel.
- Sits between the sequencer/requesters and alu_8_bit; both share CLK and RESET.

Parameters:
- DATA_W, 8: width of the operands, opcode and result.
- ALU_LATENCY, 1: number of CLK edges from the ALU sampling its inputs to ALU_OUT/CARRY being valid. Range 0..7.
- CNT_W, 16: width of the per-requester completed-operation counters.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has an operation.
- REQ0_READY  out  1  requester 0 operation accepted this cycle.
- REQ0_OP_A, REQ0_OP_B, REQ0_OPCODE  in  DATA_W each  requester 0 operation fields.
- REQ1_VALID, REQ1_READY, REQ1_OP_A, REQ1_OP_B, REQ1_OPCODE  same as above, for requester 1.
- ALU_OP_A, ALU_OP_B, ALU_OPCODE  out  DATA_W each  registered drive to the ALU.
- ALU_OUT  in  DATA_W  ALU result.
- ALU_CARRY  in  1  ALU carry.
- RSP_VALID  out  1  a response is available.
- RSP_READY  in  1  the consumer takes the response.
- RSP_ID  out  1  id of the requester that owns the response.
- RSP_RESULT  out  DATA_W  captured result.
- RSP_CARRY  out  1  captured carry.
- BUSY  out  1  high in any state other than IDLE.
- CNT0, CNT1  out  CNT_W each  completed responses per requester; saturating.

Behaviour:
- Reset values: state IDLE; all READY outputs, RSP_VALID and BUSY are 0. ALU_OP_A/B/OPCODE, RSP_RESULT, RSP_CARRY, RSP_ID, CNT0 and CNT1 are 0. The last-grant pointer is 1, so REQ0 wins the first tie.
- IDLE:
  - Grant rule: if exactly one REQn_VALID is high, grant n. If both are high, grant the requester other than the last-grant pointer.
  - REQn_READY is combinational, high only in IDLE for the granted requester, and never high for both in one cycle.
  - On the accept edge: load the operand/opcode registers, store the grant id, update the pointer, load wait counter = ALU_LATENCY, go to WAIT.
  - With no valid request, stay in IDLE.
- WAIT:
  - ALU_OP_* stay stable.
  - The counter decrements each cycle.
  - When the counter is 0 at a rising edge, that edge captures ALU_OUT/ALU_CARRY into RSP_RESULT/RSP_CARRY, sets RSP_VALID and goes to RESP.
  - The capture edge is the (ALU_LATENCY+1)-th edge after the accept edge.
- RESP:
  - RSP_VALID is high and RSP_* are held stable until RSP_READY is sampled high.
  - On that edge: clear RSP_VALID, increment CNT[RSP_ID] (saturating at all-ones, no wrap), go to IDLE.
  - No request is accepted in WAIT or RESP.
- Latency: accept in cycle c gives RSP_VALID first high in cycle c+ALU_LATENCY+2. Minimum issue interval is ALU_LATENCY+3 cycles with RSP_READY tied high.
- Next grant: RSP_READY high and a valid request pending in the same cycle means the request is granted in the following IDLE cycle, not the same cycle.
- Requester contract: a requester holds its fields stable while VALID is high and not yet accepted. A VALID drop before acceptance is legal; the request is then simply not granted.
- Opcode: passed through uninterpreted.
- RESET mid-operation: the next edge returns to IDLE and discards the in-flight operation with no response. Counters clear and the pointer returns to 1.
- ALU_LATENCY=0: WAIT lasts exactly one cycle.

Test Plan:
- Bench setup: a stub ALU with ALU_LATENCY registered stages computes {carry,sum} = OP_A+OP_B regardless of opcode.
- Single op: REQ0 with A=8'hF0, B=8'h20, RSP_READY=1. Expect REQ0_READY high in the accept cycle; RSP_VALID in cycle accept+3 (ALU_LATENCY=1) with RSP_RESULT=8'h10, RSP_CARRY=1, RSP_ID=0; CNT0=1.
- Round-robin: REQ0 and REQ1 held valid continuously. Expect grants 0,1,0,1 over 4 responses, each separated by 4 cycles. Expect CNT0=CNT1=2.
- Backpressure: RSP_READY low for 10 cycles after RSP_VALID. Expect RSP_RESULT/RSP_CARRY/RSP_ID unchanged, BUSY=1, REQ1_READY never asserted. Expect completion on the first cycle RSP_READY=1.
- Reset mid-op: assert RESET in the WAIT cycle following REQ1 acceptance. Expect no RSP_VALID; on the next cycle BUSY=0 and CNT1=0; then simultaneous requests grant REQ0 first.
- Saturation and latency: with CNT_W=2, complete 5 REQ0 ops and expect CNT0=3. With ALU_LATENCY=0, A=8'h01, B=8'hFF, expect RSP_RESULT=8'h00, RSP_CARRY=1, RSP_VALID at accept+2.
